// File: rtl/avmm_burst_bridge.sv
// Avalon-MM pipeline bridge with a command FIFO, write-burst tracking,
// an outstanding-read-beat limiter and a one-cycle registered read return path.
// Optional build macro AVMM_BRIDGE_PERF_EN adds three 32-bit performance counters
// (perf_wr_beats, perf_rd_beats, perf_stall_cyc); without it the counters and
// their ports are absent.
module avmm_burst_bridge #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BURST_W     = 4,
  parameter int CMD_DEPTH   = 4,
  parameter int MAX_RD_PEND = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [ADDR_W-1:0]     s_address,
  input  logic [BURST_W-1:0]    s_burstcount,
  input  logic [DATA_W/8-1:0]   s_byteenable,
  input  logic [DATA_W-1:0]     s_writedata,
  input  logic                  s_write,
  input  logic                  s_read,
  input  logic                  s_debugaccess,
  output logic                  s_waitrequest,
  output logic [DATA_W-1:0]     s_readdata,
  output logic                  s_readdatavalid,
  output logic [ADDR_W-1:0]     m_address,
  output logic [BURST_W-1:0]    m_burstcount,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic [DATA_W-1:0]     m_writedata,
  output logic                  m_write,
  output logic                  m_read,
  output logic                  m_debugaccess,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid
`ifdef AVMM_BRIDGE_PERF_EN
  ,
  output logic [31:0]           perf_wr_beats,
  output logic [31:0]           perf_rd_beats,
  output logic [31:0]           perf_stall_cyc
`endif
);

  localparam int BE_W   = DATA_W / 8;
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PEND_W = $clog2(MAX_RD_PEND + 1);
  localparam int SUM_W  = ((PEND_W > BURST_W) ? PEND_W : BURST_W) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] burst;
    logic [BE_W-1:0]    be;
    logic [DATA_W-1:0]  data;
    logic               wr;
    logic               rd;
    logic               dbg;
  } cmd_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_WBURST = 1'b1} wr_state_e;

  cmd_t                mem_q [CMD_DEPTH];
  cmd_t                push_cmd;
  cmd_t                head;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q;
  logic                head_valid;
  logic                accept;
  logic                pop;
  logic                rd_block;
  logic [SUM_W-1:0]    rd_need;
  wr_state_e           state_q;
  logic [BURST_W-1:0]  beat_cnt_q;
  logic [PEND_W-1:0]   pend_cnt_q, pend_cnt_d;
  logic                rd_ret;
  logic [DATA_W-1:0]   s_readdata_q;
  logic                s_readdatavalid_q;

  // Upstream handshake: stall on reset, a full queue, or a read that must wait.
  assign rd_need       = SUM_W'(pend_cnt_q) + SUM_W'(s_burstcount);
  assign rd_block      = s_read & ((rd_need > SUM_W'(MAX_RD_PEND)) | (state_q == ST_WBURST));
  assign s_waitrequest = reset_reset | full_q | rd_block;
  assign accept        = (s_write | s_read) & ~s_waitrequest;

  assign push_cmd   = {s_address, s_burstcount, s_byteenable, s_writedata,
                       s_write, s_read, s_debugaccess};
  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign pop        = head_valid & ~m_waitrequest;

  // Downstream command is the FIFO head; request strobes are gated by occupancy.
  assign m_address     = head.addr;
  assign m_burstcount  = head.burst;
  assign m_byteenable  = head.be;
  assign m_writedata   = head.data;
  assign m_debugaccess = head.dbg;
  assign m_write       = head_valid & head.wr;
  assign m_read        = head_valid & head.rd;

  // Occupancy next state from the push/pop pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage: written on accept only.
  always_ff @(posedge clk_clk) begin
    // NOTE: the storage array is deliberately not reset; pointers and count define validity.
    if (accept) mem_q[wr_ptr_q] <= push_cmd;
  end

  // FIFO pointers, occupancy and the registered full flag.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(CMD_DEPTH));
    end
  end

  // Write-burst FSM: tracks the remaining beats of a multi-beat write burst.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
    end else if (accept && s_write) begin
      case (state_q)
        ST_IDLE: begin
          if (s_burstcount > BURST_W'(1)) begin
            state_q    <= ST_WBURST;
            beat_cnt_q <= s_burstcount - BURST_W'(1);
          end
        end
        ST_WBURST: begin
          beat_cnt_q <= beat_cnt_q - BURST_W'(1);
          if (beat_cnt_q == BURST_W'(1)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outstanding read beats; returns with nothing pending are stale and ignored.
  assign rd_ret = m_readdatavalid & (pend_cnt_q != '0);

  always_comb begin
    pend_cnt_d = pend_cnt_q;
    if (accept && s_read) pend_cnt_d = pend_cnt_d + PEND_W'(s_burstcount);
    if (rd_ret)           pend_cnt_d = pend_cnt_d - PEND_W'(1);
  end

  // Pending counter and the one-cycle registered read return.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pend_cnt_q        <= '0;
      s_readdatavalid_q <= 1'b0;
      s_readdata_q      <= '0;
    end else begin
      pend_cnt_q        <= pend_cnt_d;
      s_readdatavalid_q <= rd_ret;
      if (rd_ret) s_readdata_q <= m_readdata;
    end
  end

  assign s_readdata      = s_readdata_q;
  assign s_readdatavalid = s_readdatavalid_q;

`ifdef AVMM_BRIDGE_PERF_EN
  // Free-running wrap-around counters of popped write beats, returned read beats and stalls.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      perf_wr_beats  <= '0;
      perf_rd_beats  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (pop && head.wr)                       perf_wr_beats  <= perf_wr_beats + 32'd1;
      if (rd_ret)                               perf_rd_beats  <= perf_rd_beats + 32'd1;
      if (s_waitrequest && (s_read || s_write)) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule
